// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : Instruction fetch buffer between IF and the FIFO_ID pipeline
//             register. Accepts two-slot fetch packets, compacts partially
//             valid packets, queues them in a circular buffer and presents
//             the oldest packet first-word-fall-through on the fifo_* side.
//  Ports    : clk, rstn (async active-low)
//             fetch_buf_flush              - synchronous redirect flush
//             if_valid/if_ready            - IF producer handshake
//             if_pc, if_inst0/1, if_inst_mask - IF packet
//             fifo_valid/fifo_ready        - FIFO_ID consumer handshake
//             fifo_pc, fifo_inst0/1        - head packet
//             fetch_buf_empty/full         - occupancy flags
//  Options  : FETCH_BUF_BYPASS_EN - when defined, a packet written into an
//             empty buffer is presented on fifo_* in the same cycle and is
//             not stored if fifo_ready is also high.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] INST_NOP = 32'h0340_0000,
    parameter logic [31:0] PC_RESET = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_buf_flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    input  logic [1:0]  if_inst_mask,
    output logic        fifo_valid,
    input  logic        fifo_ready,
    output logic [31:0] fifo_inst0,
    output logic [31:0] fifo_inst1,
    output logic [31:0] fifo_pc,
    output logic        fetch_buf_empty,
    output logic        fetch_buf_full
);

    localparam int             AW          = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  C_PTR_ONE   = AW'(1);
    localparam logic [AW:0]    C_CNT_ONE   = (AW+1)'(1);

    // Packet storage (not reset: contents are qualified by r_count)
    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_inst0_mem [DEPTH];
    logic [31:0] r_inst1_mem [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_wr_fire;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_cmp_pc;
    logic [31:0] w_cmp_inst0;
    logic [31:0] w_cmp_inst1;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL_CNT);

    assign if_ready        = !w_full;
    assign fetch_buf_empty = w_empty;
    assign fetch_buf_full  = w_full;

    // A packet with no valid slot still completes the handshake but is dropped.
    assign w_wr_fire = if_valid & !w_full & (if_inst_mask != 2'b00);

    // Compaction: a lone slot-1 instruction moves into slot 0 with its own PC.
    always_comb begin
        w_cmp_pc    = if_pc;
        w_cmp_inst0 = if_inst0;
        w_cmp_inst1 = if_inst1;
        case (if_inst_mask)
            2'b01: begin
                w_cmp_inst1 = INST_NOP;
            end
            2'b10: begin
                w_cmp_pc    = if_pc + 32'd4;
                w_cmp_inst0 = if_inst1;
                w_cmp_inst1 = INST_NOP;
            end
            default: ;
        endcase
    end

`ifdef FETCH_BUF_BYPASS_EN
    assign w_bypass = w_empty & !fetch_buf_flush & w_wr_fire;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed packet taken in the same cycle never enters storage.
    assign w_push = w_wr_fire & !(w_bypass & fifo_ready);
    assign w_pop  = fifo_ready & !w_empty;

    assign fifo_valid = !w_empty | w_bypass;

    always_comb begin
        if (w_bypass) begin
            fifo_pc    = w_cmp_pc;
            fifo_inst0 = w_cmp_inst0;
            fifo_inst1 = w_cmp_inst1;
        end else if (w_empty) begin
            fifo_pc    = PC_RESET;
            fifo_inst0 = INST_NOP;
            fifo_inst1 = INST_NOP;
        end else begin
            fifo_pc    = r_pc_mem[r_head];
            fifo_inst0 = r_inst0_mem[r_head];
            fifo_inst1 = r_inst1_mem[r_head];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (fetch_buf_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + C_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !fetch_buf_flush) begin
            r_pc_mem[r_tail]    <= w_cmp_pc;
            r_inst0_mem[r_tail] <= w_cmp_inst0;
            r_inst1_mem[r_tail] <= w_cmp_inst1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_buffer
//  Purpose  : Self-checking bench for fetch_buffer: directed vector table,
//             hand-written corner sequences and randomized traffic checked
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0340_0000;
    localparam logic [31:0] PCR   = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst0 = '0;
    logic [31:0] if_inst1 = '0;
    logic [1:0]  if_mask = '0;
    logic        fifo_valid;
    logic        fifo_ready = 1'b0;
    logic [31:0] fifo_inst0;
    logic [31:0] fifo_inst1;
    logic [31:0] fifo_pc;
    logic        buf_empty;
    logic        buf_full;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .fetch_buf_flush (flush),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst0        (if_inst0),
        .if_inst1        (if_inst1),
        .if_inst_mask    (if_mask),
        .fifo_valid      (fifo_valid),
        .fifo_ready      (fifo_ready),
        .fifo_inst0      (fifo_inst0),
        .fifo_inst1      (fifo_inst1),
        .fifo_pc         (fifo_pc),
        .fetch_buf_empty (buf_empty),
        .fetch_buf_full  (buf_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
    } pkt_t;

    pkt_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Predictions for the upcoming edge, computed by check_model
    logic p_wr, p_byp;

    function automatic pkt_t compact(input logic [1:0] m, input logic [31:0] p,
                                     input logic [31:0] a, input logic [31:0] b);
        pkt_t r;
        if (m == 2'b11)      begin r.pc = p;          r.i0 = a; r.i1 = b;   end
        else if (m == 2'b01) begin r.pc = p;          r.i0 = a; r.i1 = NOP; end
        else                 begin r.pc = p + 32'd4;  r.i0 = b; r.i1 = NOP; end
        return r;
    endfunction

    task automatic check_model(input string name);
        logic e_empty, e_full, e_valid;
        pkt_t h;
        e_empty = (q.size() == 0);
        e_full  = (q.size() == DEPTH);
        p_wr    = if_valid && !e_full && (if_mask != 2'b00);
        p_byp   = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        p_byp   = e_empty && !flush && p_wr;
`endif
        e_valid = !e_empty || p_byp;
        if (p_byp)        h = compact(if_mask, if_pc, if_inst0, if_inst1);
        else if (e_empty) begin h.pc = PCR; h.i0 = NOP; h.i1 = NOP; end
        else              h = q[0];
        n_vec++;
        if (fifo_valid !== e_valid || buf_empty !== e_empty || buf_full !== e_full ||
            if_ready !== !e_full || fifo_pc !== h.pc || fifo_inst0 !== h.i0 ||
            fifo_inst1 !== h.i1) begin
            n_err++;
            $display("FAIL %s: got v=%b e=%b f=%b r=%b pc=%h i0=%h i1=%h, expected v=%b e=%b f=%b r=%b pc=%h i0=%h i1=%h",
                     name, fifo_valid, buf_empty, buf_full, if_ready, fifo_pc, fifo_inst0,
                     fifo_inst1, e_valid, e_empty, e_full, !e_full, h.pc, h.i0, h.i1);
        end
    endtask

    task automatic advance();
        logic rd;
        rd = (q.size() != 0) && fifo_ready;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (rd) void'(q.pop_front());
            if (p_wr && !(p_byp && fifo_ready))
                q.push_back(compact(if_mask, if_pc, if_inst0, if_inst1));
        end
        #1;
    endtask

    task automatic step(input string name);
        #1;
        check_model(name);
        advance();
    endtask

    task automatic drive(input logic f, input logic v, input logic [1:0] m,
                         input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        flush = f; if_valid = v; if_mask = m; if_pc = p;
        if_inst0 = a; if_inst1 = b; fifo_ready = r;
    endtask

    task automatic expect1(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    typedef struct packed {
        logic        f;
        logic        v;
        logic [1:0]  m;
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        r;
        logic        e_valid;
        logic        e_empty;
        logic        e_full;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_i0;
        logic [31:0] e_i1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Directed vectors: inputs for a cycle and the outputs seen before its edge
        tbl[0] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b1, PCR, NOP, NOP};
        tbl[1] = '{1'b0, 1'b1, 2'b10, 32'h1c000000, 32'h11111111, 32'h02800421, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b1, PCR, NOP, NOP};
        tbl[2] = '{1'b0, 1'b1, 2'b00, 32'h1c000008, 32'h22222222, 32'h33333333, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000004, 32'h02800421, NOP};
        tbl[3] = '{1'b0, 1'b1, 2'b01, 32'h1c000010, 32'haaaa0001, 32'hbbbb0001, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000004, 32'h02800421, NOP};
        tbl[4] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000010, 32'haaaa0001, NOP};
        tbl[5] = '{1'b1, 1'b1, 2'b11, 32'h1c000020, 32'hc1c1c1c1, 32'hc2c2c2c2, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000010, 32'haaaa0001, NOP};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b1, PCR, NOP, NOP};
        tbl[7] = '{1'b0, 1'b1, 2'b11, 32'h1c000030, 32'hd1d1d1d1, 32'hd2d2d2d2, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b1, PCR, NOP, NOP};
        tbl[8] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000030, 32'hd1d1d1d1, 32'hd2d2d2d2};
        tbl[9] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b1, PCR, NOP, NOP};

        // Reset held for a few cycles, released between edges
        #1;
        expect1("reset_empty", buf_empty, 1'b1);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // ---- vector table ----
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].f, tbl[i].v, tbl[i].m, tbl[i].pc, tbl[i].i0, tbl[i].i1, tbl[i].r);
            #1;
`ifndef FETCH_BUF_BYPASS_EN
            n_vec++;
            if (fifo_valid !== tbl[i].e_valid || buf_empty !== tbl[i].e_empty ||
                buf_full !== tbl[i].e_full || if_ready !== tbl[i].e_ready ||
                fifo_pc !== tbl[i].e_pc || fifo_inst0 !== tbl[i].e_i0 ||
                fifo_inst1 !== tbl[i].e_i1) begin
                n_err++;
                $display("FAIL vec%0d: got v=%b e=%b f=%b r=%b pc=%h i0=%h i1=%h, expected v=%b e=%b f=%b r=%b pc=%h i0=%h i1=%h",
                         i, fifo_valid, buf_empty, buf_full, if_ready, fifo_pc, fifo_inst0,
                         fifo_inst1, tbl[i].e_valid, tbl[i].e_empty, tbl[i].e_full,
                         tbl[i].e_ready, tbl[i].e_pc, tbl[i].e_i0, tbl[i].e_i1);
            end
`endif
            check_model($sformatf("vec%0d_model", i));
            advance();
        end

        // ---- fill to full, hold the 9th, drain in order ----
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b1, 2'b11, 32'h1c000000 + 32'(8 * k), 32'h10000000 + 32'(k),
                  32'h20000000 + 32'(k), 1'b0);
            step("fill");
        end
        #1;
        expect1("full_after_8", buf_full, 1'b1);
        expect1("if_ready_low_full", if_ready, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 32'h1c000040, 32'h10000008, 32'h20000008, 1'b0);
        repeat (3) step("hold9");
        fifo_ready = 1'b1;
        step("read_full");
        step("write9_read");
        if_valid = 1'b0;
        repeat (DEPTH) step("drain");
        #1;
        expect1("empty_after_drain", buf_empty, 1'b1);

        // ---- mask 00 with if_valid while empty ----
        drive(1'b0, 1'b1, 2'b00, 32'h1c000100, 32'h1, 32'h2, 1'b0);
        #1;
        expect1("mask00_ready", if_ready, 1'b1);
        step("mask00");
        if_valid = 1'b0;
        #1;
        expect1("mask00_no_valid", fifo_valid, 1'b0);

        // ---- flush with simultaneous write and read ----
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 2'b11, 32'h1c000200 + 32'(8 * k), 32'h30000000 + 32'(k),
                  32'h40000000 + 32'(k), 1'b0);
            step("pre_flush");
        end
        drive(1'b1, 1'b1, 2'b11, 32'h1c000300, 32'h5eed0000, 32'h5eed0001, 1'b1);
        step("flush_cycle");
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        expect1("flush_empty", buf_empty, 1'b1);
        expect1("flush_no_valid", fifo_valid, 1'b0);

        // ---- steady read+write at count 3, then reset mid-stream ----
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 2'b11, 32'h1c000400 + 32'(8 * k), 32'h60000000 + 32'(k),
                  32'h70000000 + 32'(k), 1'b0);
            step("prime3");
        end
        for (int k = 3; k < 28; k++) begin
            drive(1'b0, 1'b1, 2'b11, 32'h1c000400 + 32'(8 * k), 32'h60000000 + 32'(k),
                  32'h70000000 + 32'(k), 1'b1);
            step("steady3");
        end
        expect1("steady_count3", q.size() == 3, 1'b1);
        #2 rstn = 1'b0;
        #1;
        expect1("rst_mid_empty", buf_empty, 1'b1);
        expect1("rst_mid_no_valid", fifo_valid, 1'b0);
        q.delete();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

`ifdef FETCH_BUF_BYPASS_EN
        // ---- same-cycle bypass into an empty buffer ----
        drive(1'b0, 1'b1, 2'b11, 32'h1c000800, 32'hbeef0000, 32'hbeef0001, 1'b1);
        #1;
        expect1("byp_valid", fifo_valid, 1'b1);
        expect1("byp_pc", fifo_pc == 32'h1c000800, 1'b1);
        check_model("byp_model");
        advance();
        if_valid = 1'b0;
        #1;
        expect1("byp_not_stored", buf_empty, 1'b1);
`endif

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            int pr;
            logic [31:0] v;
            pr = ((c / 150) % 3 == 0) ? 20 : (((c / 150) % 3 == 1) ? 80 : 50);
            v = $urandom();
            flush      = ($urandom_range(0, 39) == 0);
            if_valid   = ($urandom_range(0, 99) < 65);
            if_mask    = 2'($urandom_range(0, 3));
            if_pc      = v & 32'hffff_fffc;
            if_inst0   = $urandom();
            if_inst1   = $urandom();
            fifo_ready = ($urandom_range(0, 99) < pr);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
